// File: rtl/pokey_bus_arb_pkg.sv
// Shared types and constants for the POKEY bus arbiter and its E-clock generator.
package pokey_bus_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ACK,
    ST_SCAN
  } state_e;

  localparam logic [3:0] POTGO_ADDR   = 4'hB;
  localparam logic [7:0] FF_READ      = 8'hFF;
  localparam int         NDEV_DEFAULT = 3;

endpackage

// File: rtl/pokey_bus_arb_eclk_gen.sv
// Free-running E-clock phase counter: E level, last-high-cycle enable and the
// pre-rise strobe that lets a queued access line up with the next E-high window.
module pokey_bus_arb_eclk_gen #(
  parameter int EDIV = 10,
  parameter int E_HI = 4
) (
  input  logic cl,
  input  logic rst_n,
  output logic e_phase,
  output logic e_en,
  output logic pre_rise
);

  localparam int ECW = $clog2(EDIV);

  logic [ECW-1:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = (ecnt_q == ECW'(EDIV - 1)) ? '0 : ecnt_q + ECW'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge cl or negedge rst_n) begin
    if (!rst_n) ecnt_q <= '0;
    else        ecnt_q <= ecnt_d;
  end

  assign e_phase  = (ecnt_q >= ECW'(EDIV - E_HI));
  assign e_en     = (ecnt_q == ECW'(EDIV - 1));
  assign pre_rise = (ecnt_q == ECW'(EDIV - E_HI - 1));

endmodule

// File: rtl/pokey_bus_arb.sv
// Schedules CPU byte accesses and periodic POTGO broadcasts onto the shared
// POKEY strobe bus, one access per E-high window.
module pokey_bus_arb
  import pokey_bus_arb_pkg::*;
#(
  parameter int NDEV        = NDEV_DEFAULT,
  parameter int EDIV        = 10,
  parameter int E_HI        = 4,
  parameter int SCAN_PERIOD = 64
) (
  input  logic              cl,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [NDEV-1:0]   cpu_sel,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_addr,
  input  logic [7:0]        cpu_wd,
  output logic [7:0]        cpu_rd,
  output logic              cpu_dtack,
  output logic              e_en,
  output logic              e_phase,
  output logic [NDEV-1:0]   dev_cs,
  output logic              dev_we,
  output logic [3:0]        dev_addr,
  output logic [7:0]        dev_wd,
  input  logic [8*NDEV-1:0] dev_rd,
  input  logic              scan_en,
  output logic              scan_busy
);

  localparam int SCW = $clog2(SCAN_PERIOD);

  logic pre_rise;

  pokey_bus_arb_eclk_gen #(
    .EDIV (EDIV),
    .E_HI (E_HI)
  ) u_eclk (
    .cl       (cl),
    .rst_n    (rst_n),
    .e_phase  (e_phase),
    .e_en     (e_en),
    .pre_rise (pre_rise)
  );

  state_e          state_q, state_d;
  logic            scan_q, scan_d;       // the pending WAIT belongs to a POTGO broadcast
  logic [NDEV-1:0] sel_q, sel_d;
  logic            we_q, we_d;
  logic [3:0]      addr_q, addr_d;
  logic [7:0]      wd_q, wd_d;
  logic [7:0]      rd_q, rd_d;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic            pend_q, pend_d;
  logic            serve_scan;
  logic [7:0]      rd_mux;

  // sel_q is already reduced to one-hot, so an OR of the masked lanes is the mux.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (sel_q[i]) rd_mux = rd_mux | dev_rd[8*i +: 8];
    end
    if (sel_q == '0) rd_mux = FF_READ;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_d    = state_q;
    scan_d     = scan_q;
    sel_d      = sel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    rd_d       = rd_q;
    serve_scan = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          sel_d   = cpu_sel & (~cpu_sel + NDEV'(1));  // lowest set bit wins
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wd_d    = cpu_wd;
          scan_d  = 1'b0;
          state_d = ST_WAIT;
        end else if (pend_q) begin
          scan_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pre_rise) state_d = scan_q ? ST_SCAN : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (e_en) begin
          if (!we_q) rd_d = rd_mux;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!cpu_req) state_d = ST_IDLE;
      end
      ST_SCAN: begin
        if (e_en) begin
          serve_scan = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new request on the serving edge must win over the clear.
  always_comb begin
    scnt_d = scnt_q;
    pend_d = pend_q;
    if (!scan_en) begin
      scnt_d = '0;
      pend_d = 1'b0;
    end else begin
      if (serve_scan) pend_d = 1'b0;
      if (e_en) begin
        if (scnt_q == SCW'(SCAN_PERIOD - 1)) begin
          scnt_d = '0;
          pend_d = 1'b1;
        end else begin
          scnt_d = scnt_q + SCW'(1);
        end
      end
    end
  end

  // NOTE: the request latch and read register are reset along with the FSM so
  // the bus outputs and cpu_rd are defined from the first cycle after reset.
  always_ff @(posedge cl or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      scan_q  <= 1'b0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      scnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      scnt_q  <= scnt_d;
      pend_q  <= pend_d;
    end
  end

  // Bus outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    dev_cs   = '0;
    dev_we   = 1'b0;
    dev_addr = '0;
    dev_wd   = '0;
    if (state_q == ST_ACCESS) begin
      dev_cs   = sel_q;
      dev_we   = we_q;
      dev_addr = addr_q;
      dev_wd   = wd_q;
    end else if (state_q == ST_SCAN) begin
      dev_cs   = '1;
      dev_we   = 1'b1;
      dev_addr = POTGO_ADDR;
      dev_wd   = 8'h00;
    end
  end

  assign cpu_rd    = rd_q;
  assign cpu_dtack = (state_q == ST_ACK);
  assign scan_busy = ((state_q == ST_WAIT) && scan_q) || (state_q == ST_SCAN);

endmodule

// File: tb/tb_pokey_bus_arb.sv
// Randomised bench for pokey_bus_arb against a window-arithmetic reference model.
module tb_pokey_bus_arb;

  localparam int NDEV = 3;
  localparam int EDIV = 10;
  localparam int E_HI = 4;
  localparam int SP   = 2;

  localparam int M_IDLE = 0;
  localparam int M_CPU  = 1;
  localparam int M_ACK  = 2;
  localparam int M_SCAN = 3;

  logic        cl = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [2:0]  cpu_sel = '0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_addr = '0;
  logic [7:0]  cpu_wd = '0;
  logic [7:0]  cpu_rd;
  logic        cpu_dtack;
  logic        e_en;
  logic        e_phase;
  logic [2:0]  dev_cs;
  logic        dev_we;
  logic [3:0]  dev_addr;
  logic [7:0]  dev_wd;
  logic [23:0] dev_rd = '0;
  logic        scan_en = 1'b0;
  logic        scan_busy;

  always #5 cl = ~cl;

  pokey_bus_arb #(
    .NDEV        (NDEV),
    .EDIV        (EDIV),
    .E_HI        (E_HI),
    .SCAN_PERIOD (SP)
  ) dut (
    .cl        (cl),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_sel   (cpu_sel),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wd    (cpu_wd),
    .cpu_rd    (cpu_rd),
    .cpu_dtack (cpu_dtack),
    .e_en      (e_en),
    .e_phase   (e_phase),
    .dev_cs    (dev_cs),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wd    (dev_wd),
    .dev_rd    (dev_rd),
    .scan_en   (scan_en),
    .scan_busy (scan_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: which owner holds the bus and the absolute cycle of its window.
  int         m_mode;
  int         m_win;
  logic [2:0] m_sel;
  logic       m_we;
  logic [3:0] m_addr;
  logic [7:0] m_wd;
  logic [7:0] m_rd;
  int         m_cnt;
  bit         m_pend;

  bit drv_on = 1'b0;
  bit traffic_en = 1'b0;
  bit dt_seen = 1'b0;
  bit first_run = 1'b1;
  int gap = 0;
  int hold = 0;
  int req_start = 0;
  int txn = 0;
  int dir_idx = 0;

  logic [2:0] d_sel  [4] = '{3'b010, 3'b100, 3'b000, 3'b110};
  logic       d_we   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0] d_addr [4] = '{4'h8, 4'h3, 4'h5, 4'h2};
  logic [7:0] d_wd   [4] = '{8'h5A, 8'h00, 8'h00, 8'h77};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [2:0] s);
    for (int i = 0; i < NDEV; i++) if (s[i]) return 3'(1 << i);
    return 3'b000;
  endfunction

  function automatic logic [7:0] rd_of(input logic [2:0] s, input logic [23:0] d);
    for (int i = 0; i < NDEV; i++) if (s[i]) return d[8*i +: 8];
    return 8'hFF;
  endfunction

  // First cycle at or after t whose E-phase position is the first E-high cycle.
  function automatic int next_win(input int t);
    return t + (((EDIV - E_HI) - (t % EDIV)) + EDIV) % EDIV;
  endfunction

  task automatic model_reset();
    cyc    = 0;
    m_mode = M_IDLE;
    m_win  = 0;
    m_sel  = '0;
    m_we   = 1'b0;
    m_addr = '0;
    m_wd   = '0;
    m_rd   = '0;
    m_cnt  = 0;
    m_pend = 1'b0;
  endtask

  task automatic chk_outputs();
    int         e;
    bit         in_win;
    logic [2:0] cs;
    logic       we;
    logic [3:0] a;
    logic [7:0] wd;
    e      = cyc % EDIV;
    in_win = (m_mode == M_CPU || m_mode == M_SCAN) && cyc >= m_win && cyc < m_win + E_HI;
    cs = '0; we = 1'b0; a = '0; wd = '0;
    if (in_win && m_mode == M_SCAN) begin
      cs = 3'b111; we = 1'b1; a = 4'hB; wd = 8'h00;
    end else if (in_win) begin
      cs = lowest(m_sel); we = m_we; a = m_addr; wd = m_wd;
    end
    check("e_phase",   e_phase,   e >= EDIV - E_HI);
    check("e_en",      e_en,      e == EDIV - 1);
    check("dev_cs",    dev_cs,    cs);
    check("dev_we",    dev_we,    we);
    check("dev_addr",  dev_addr,  a);
    check("dev_wd",    dev_wd,    wd);
    check("cpu_dtack", cpu_dtack, m_mode == M_ACK);
    check("cpu_rd",    cpu_rd,    m_rd);
    check("scan_busy", scan_busy, m_mode == M_SCAN);
  endtask

  task automatic model_update();
    bit served;
    served = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (cpu_req) begin
          m_mode = M_CPU;
          m_win  = next_win(cyc + 2);
          m_sel  = cpu_sel;
          m_we   = cpu_we;
          m_addr = cpu_addr;
          m_wd   = cpu_wd;
        end else if (m_pend) begin
          m_mode = M_SCAN;
          m_win  = next_win(cyc + 2);
        end
      end
      M_CPU: if (cyc == m_win + E_HI - 1) begin
        if (!m_we) m_rd = rd_of(m_sel, dev_rd);
        m_mode = M_ACK;
      end
      M_ACK: if (!cpu_req) m_mode = M_IDLE;
      M_SCAN: if (cyc == m_win + E_HI - 1) begin
        m_mode = M_IDLE;
        served = 1'b1;
      end
      default: ;
    endcase
    if (!scan_en) begin
      m_cnt  = 0;
      m_pend = 1'b0;
    end else begin
      if (served) m_pend = 1'b0;
      if (cyc % EDIV == EDIV - 1) begin
        m_cnt++;
        if (m_cnt == SP) begin
          m_cnt  = 0;
          m_pend = 1'b1;
        end
      end
    end
  endtask

  task automatic drive_inputs();
    dev_rd = 24'($urandom);
    if (first_run && txn <= 4) dev_rd[23:16] = 8'hC3;
    if (!drv_on) begin
      if (traffic_en && gap == 0) begin
        drv_on    = 1'b1;
        txn++;
        req_start = cyc;
        dt_seen   = 1'b0;
        if (dir_idx < 4) begin
          cpu_sel  = d_sel[dir_idx];
          cpu_we   = d_we[dir_idx];
          cpu_addr = d_addr[dir_idx];
          cpu_wd   = d_wd[dir_idx];
          hold     = 3;
          dir_idx++;
        end else begin
          cpu_sel  = 3'($urandom);
          cpu_we   = 1'($urandom);
          cpu_addr = 4'($urandom);
          cpu_wd   = 8'($urandom);
          hold     = $urandom_range(0, 3);
        end
      end else if (gap > 0) begin
        gap--;
      end
    end else if (m_mode == M_ACK) begin
      if (hold > 0) hold--;
      else begin
        drv_on = 1'b0;
        gap    = $urandom_range(0, 12);
      end
    end
    cpu_req = drv_on;
  endtask

  task automatic step();
    chk_outputs();
    if (cpu_dtack === 1'b1 && drv_on && !dt_seen) begin
      dt_seen = 1'b1;
      if (txn == 1) check("first_dtack_latency", 32'(cyc - req_start), 10);
      if (first_run && txn == 2) check("read_sel100", cpu_rd, 8'hC3);
      if (first_run && txn == 3) check("read_sel000", cpu_rd, 8'hFF);
    end
    drive_inputs();
    model_update();
    cyc++;
    @(negedge cl);
  endtask

  initial begin
    repeat (3) @(negedge cl);
    check("rst_e_phase",   e_phase,   0);
    check("rst_e_en",      e_en,      0);
    check("rst_dev_cs",    dev_cs,    0);
    check("rst_dev_we",    dev_we,    0);
    check("rst_dev_addr",  dev_addr,  0);
    check("rst_dev_wd",    dev_wd,    0);
    check("rst_cpu_dtack", cpu_dtack, 0);
    check("rst_cpu_rd",    cpu_rd,    0);
    check("rst_scan_busy", scan_busy, 0);
    #1 rst_n = 1'b1;
    model_reset();
    traffic_en = 1'b1;

    // Directed transactions first, then random traffic without scanning.
    repeat (400) step();

    // Random traffic with scanning switched on and off in segments.
    for (int k = 0; k < 15; k++) begin
      scan_en = ($urandom_range(0, 3) != 0);
      repeat (100) step();
    end

    // Scanning alone: POTGO broadcast every second E period.
    traffic_en = 1'b0;
    scan_en    = 1'b1;
    repeat (200) step();

    // Reset in the middle of a CPU access window.
    traffic_en = 1'b1;
    begin : mid_reset
      int guard;
      guard = 0;
      while (!(m_mode == M_CPU && cyc >= m_win && cyc < m_win + E_HI) && guard < 200) begin
        step();
        guard++;
      end
      check("reach_access", guard < 200, 1);
      rst_n = 1'b0;
      #1;
      check("arst_dev_cs",    dev_cs,    0);
      check("arst_dev_we",    dev_we,    0);
      check("arst_cpu_dtack", cpu_dtack, 0);
      check("arst_scan_busy", scan_busy, 0);
      cpu_req = 1'b0;
      drv_on  = 1'b0;
      repeat (2) @(negedge cl);
      #1 rst_n = 1'b1;
      model_reset();
      gap       = 0;
      txn       = 0;
      first_run = 1'b0;
    end

    for (int k = 0; k < 5; k++) begin
      scan_en = 1'($urandom);
      repeat (100) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
